// File: rtl/ram512_loader_if.sv
// Byte-stream and RAM-pin bundle for the RAM preloader.
// The master side is the loader: it consumes bytes and drives the RAM pins.
// The slave side is the surrounding system: byte source plus the RAM block.
interface ram512_loader_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              ram_load;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_in;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, ram_load, ram_address, ram_in
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, ram_load, ram_address, ram_in
  );
endinterface

// File: rtl/ram512_loader.sv
// Preloader for the 512 x 16 RAM: pairs incoming bytes into big-endian
// words and writes them to consecutive addresses from a programmable base,
// keeping a running checksum and word count for the current/last job.
module ram512_loader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  ram512_loader_if.master   bus,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GET_HI = 2'd1,
    GET_LO = 2'd2,
    WRITE  = 2'd3
  } state_t;

  // A word_count of zero stands for a full sweep of the RAM.
  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  state_t state, next_state;

  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W:0]   remaining;
  logic [7:0]        word_hi;
  logic              ram_load_r;
  logic [ADDR_W-1:0] ram_address_r;
  logic [DATA_W-1:0] ram_in_r;
  logic              done_r;
  logic [DATA_W-1:0] checksum_r;
  logic [ADDR_W:0]   words_written_r;

  logic accept_start;
  logic latch_hi;
  logic latch_lo;
  logic commit;
  logic finish_ok;
  logic ready_c;

  // State register; reset drops any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and per-cycle control strobes; abort beats a byte handshake
  // but never cancels a write already on the RAM pins.
  always_comb begin
    next_state   = state;
    accept_start = 1'b0;
    latch_hi     = 1'b0;
    latch_lo     = 1'b0;
    commit       = 1'b0;
    finish_ok    = 1'b0;
    ready_c      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          next_state   = GET_HI;
        end
      end
      GET_HI: begin
        ready_c = 1'b1;
        if (abort) begin
          next_state = IDLE;
        end else if (bus.byte_valid) begin
          latch_hi   = 1'b1;
          next_state = GET_LO;
        end
      end
      GET_LO: begin
        ready_c = 1'b1;
        if (abort) begin
          next_state = IDLE;
        end else if (bus.byte_valid) begin
          latch_lo   = 1'b1;
          next_state = WRITE;
        end
      end
      WRITE: begin
        commit = 1'b1;
        if (abort) begin
          next_state = IDLE;
        end else if (remaining == (ADDR_W+1)'(1)) begin
          finish_ok  = 1'b1;
          next_state = IDLE;
        end else begin
          next_state = GET_HI;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Job counters, byte assembly and the registered RAM pins; the RAM pins
  // are loaded on the low-byte handshake so they are stable during WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt        <= '0;
      remaining       <= '0;
      word_hi         <= '0;
      ram_load_r      <= 1'b0;
      ram_address_r   <= '0;
      ram_in_r        <= '0;
      done_r          <= 1'b0;
      checksum_r      <= '0;
      words_written_r <= '0;
    end else begin
      ram_load_r <= latch_lo;
      if (accept_start) begin
        addr_cnt        <= base_addr;
        remaining       <= (word_count == '0) ? FULL_COUNT : word_count;
        checksum_r      <= '0;
        words_written_r <= '0;
        done_r          <= 1'b0;
      end
      if (latch_hi) begin
        word_hi <= bus.byte_data;
      end
      if (latch_lo) begin
        ram_address_r <= addr_cnt;
        ram_in_r      <= {word_hi, bus.byte_data};
      end
      if (commit) begin
        addr_cnt        <= addr_cnt + ADDR_W'(1);
        checksum_r      <= checksum_r + ram_in_r;
        words_written_r <= words_written_r + (ADDR_W+1)'(1);
        remaining       <= remaining - (ADDR_W+1)'(1);
      end
      if (finish_ok) begin
        done_r <= 1'b1;
      end
    end
  end

  assign bus.byte_ready  = ready_c;
  assign bus.ram_load    = ram_load_r;
  assign bus.ram_address = ram_address_r;
  assign bus.ram_in      = ram_in_r;
  assign busy            = (state != IDLE);
  assign done            = done_r;
  assign checksum        = checksum_r;
  assign words_written   = words_written_r;

endmodule

// File: tb/tb_ram512_loader.sv
// Self-checking bench for the RAM preloader: random byte streams with
// random valid gaps, checked against a word/address list built from the
// job parameters and a shadow of the RAM contents.
module tb_ram512_loader;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic              abort;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] checksum;
  logic [ADDR_W:0]   words_written;

  ram512_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram512_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .word_count    (word_count),
    .abort         (abort),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .checksum      (checksum),
    .words_written (words_written)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: what the current job should have written, in order.
  int          jobBase;
  int          jobIdx;
  int          expAddrs[$];
  logic [15:0] expWords[$];

  // What the RAM pins actually carried, plus a shadow of RAM contents.
  int          capAddrs[$];
  logic [15:0] capWords[$];
  logic [15:0] tbMem[DEPTH];
  logic        prevLoad = 1'b0;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Record every RAM write; a write must be a single cycle and never
  // overlap a cycle in which the loader is taking bytes.
  always @(negedge clk) begin
    if (bus.ram_load === 1'b1) begin
      checkOutput("loadExclusive", {30'd0, prevLoad, bus.byte_ready}, 32'd0);
      capAddrs.push_back(int'(bus.ram_address));
      capWords.push_back(bus.ram_in);
      tbMem[bus.ram_address] = bus.ram_in;
    end
    prevLoad = bus.ram_load;
  end

  // Offer one byte after an optional idle gap and hold it until taken.
  task automatic sendByte(input logic [7:0] b, input int gap);
    for (int g = 0; g < gap; g++) begin
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int t = 0; t < 100; t++) begin
      if (bus.byte_ready) begin
        @(negedge clk);
        bus.byte_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    checkOutput("handshakeTimeout", 32'd1, 32'd0);
    bus.byte_valid = 1'b0;
  endtask

  // Send one word; the write must appear the cycle after the low byte.
  task automatic sendWord(input logic [7:0] hi, input logic [7:0] lo, input int gapMax);
    int          addr;
    logic [15:0] word;
    sendByte(hi, $urandom_range(gapMax, 0));
    sendByte(lo, $urandom_range(gapMax, 0));
    addr = (jobBase + jobIdx) % DEPTH;
    word = {hi, lo};
    expAddrs.push_back(addr);
    expWords.push_back(word);
    jobIdx++;
    checkOutput("writeLoad", {31'd0, bus.ram_load}, 32'd1);
    checkOutput("writeAddr", {23'd0, bus.ram_address}, addr);
    checkOutput("writeData", {16'd0, bus.ram_in}, {16'd0, word});
  endtask

  task automatic startJob(input int base, input int count, input bit withAbort);
    capAddrs.delete();
    capWords.delete();
    expAddrs.delete();
    expWords.delete();
    jobBase    = base;
    jobIdx     = 0;
    base_addr  = ADDR_W'(base);
    word_count = (ADDR_W+1)'(count);
    start      = 1'b1;
    abort      = withAbort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("startBusy", {31'd0, busy}, 32'd1);
    checkOutput("startDone", {31'd0, done}, 32'd0);
    checkOutput("startCount", {22'd0, words_written}, 32'd0);
    checkOutput("startSum", {16'd0, checksum}, 32'd0);
  endtask

  // Wait for the job to end, then compare everything against the model.
  task automatic checkJob(input bit expDone);
    logic [15:0] sum = 16'd0;
    int          waited = 0;
    while (busy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("jobEnded", {31'd0, busy}, 32'd0);
    foreach (expWords[i]) sum += expWords[i];
    checkOutput("jobDone", {31'd0, done}, {31'd0, expDone});
    checkOutput("jobWordsWritten", {22'd0, words_written}, expWords.size());
    checkOutput("jobChecksum", {16'd0, checksum}, {16'd0, sum});
    checkOutput("jobWriteCount", capWords.size(), expWords.size());
    if (capWords.size() == expWords.size()) begin
      foreach (expWords[i]) begin
        checkOutput("capAddr", capAddrs[i], expAddrs[i]);
        checkOutput("capWord", {16'd0, capWords[i]}, {16'd0, expWords[i]});
      end
    end
  endtask

  // One complete job; pattern selects word i = i, otherwise random bytes.
  task automatic applyStimulus(input int base, input int count, input int gapMax,
                               input bit midStart, input bit withAbort, input bit pattern);
    int n = (count == 0) ? DEPTH : count;
    startJob(base, count, withAbort);
    for (int i = 0; i < n; i++) begin
      if (pattern) sendWord(8'(i >> 8), 8'(i), gapMax);
      else         sendWord(8'($urandom), 8'($urandom), gapMax);
      if (midStart && i == 1) begin
        base_addr  = ADDR_W'($urandom);
        word_count = (ADDR_W+1)'(1);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    checkJob(1'b1);
  endtask

  task automatic applyFixedJob(input int base, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3,
                               input logic [15:0] expSum);
    startJob(base, 2, 1'b0);
    sendWord(b0, b1, 0);
    sendWord(b2, b3, 0);
    checkJob(1'b1);
    checkOutput("fixedChecksum", {16'd0, checksum}, {16'd0, expSum});
  endtask

  // Main sequence.
  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    abort          = 1'b0;
    base_addr      = '0;
    word_count     = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    foreach (tbMem[i]) tbMem[i] = 16'd0;
    repeat (3) @(negedge clk);
    checkOutput("rstOutputs", {busy, done, bus.byte_ready, bus.ram_load, 28'd0}, 32'd0);
    checkOutput("rstBus", {bus.ram_address, bus.ram_in}, 32'd0);
    checkOutput("rstCounts", {checksum, 6'd0, words_written}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed jobs");
    applyFixedJob(32'h010, 8'h12, 8'h34, 8'hAB, 8'hCD, 16'hBE01);
    applyFixedJob(32'h1FF, 8'h00, 8'h01, 8'h00, 8'h02, 16'h0003);

    $display("[TB] full sweep from base 0x005");
    applyStimulus(5, 0, 0, 1'b0, 1'b0, 1'b1);
    checkOutput("sweepLastAddr", capAddrs[capAddrs.size()-1], 32'h004);
    checkOutput("sweepSum", {16'd0, checksum}, 32'hFF00);

    $display("[TB] gapped stream with start while busy");
    applyStimulus(32'h0A0, 3, 4, 1'b1, 1'b0, 1'b0);

    $display("[TB] random jobs");
    for (int j = 0; j < 6; j++) begin
      applyStimulus($urandom_range(DEPTH-1, 0), $urandom_range(12, 1), 3,
                    1'($urandom), 1'($urandom), 1'b0);
    end

    $display("[TB] abort in GET_LO");
    startJob(32'h100, 4, 1'b0);
    sendWord(8'h5A, 8'hA5, 2);
    sendByte(8'h77, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkJob(1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("idleAbortBusy", {31'd0, busy}, 32'd0);
    checkOutput("idleAbortCount", {22'd0, words_written}, 32'd1);
    applyStimulus(32'h150, 3, 1, 1'b0, 1'b0, 1'b0);

    $display("[TB] abort during WRITE");
    startJob(32'h020, 3, 1'b0);
    sendWord(8'hC3, 8'h3C, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkJob(1'b0);

    $display("[TB] reset mid-job");
    startJob(32'h033, 3, 1'b0);
    sendWord(8'hDE, 8'hAD, 0);
    sendByte(8'hBE, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstOutputs", {busy, done, bus.byte_ready, bus.ram_load, 28'd0}, 32'd0);
    checkOutput("midRstBus", {bus.ram_address, bus.ram_in}, 32'd0);
    checkOutput("midRstCounts", {checksum, 6'd0, words_written}, 32'd0);
    checkOutput("midRstRamKept", {16'd0, tbMem[32'h033]}, 32'hDEAD);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("postRstIdle", {busy, bus.byte_ready, 30'd0}, 32'd0);
    checkOutput("postRstNoWrites", capWords.size(), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
